// File: rtl/parity_arb_pkg.sv
// Shared types and constants for the two-channel parity arbiter controller.
package parity_arb_pkg;

  // Result-register occupancy
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  // Per-request operation select
  localparam logic MODE_GEN = 1'b0;
  localparam logic MODE_CHK = 1'b1;

  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_CNT_W  = 8;

endpackage

// File: rtl/parity_arb_ctrl_parity_unit.sv
// Purpose: combinational parity generate/check on one byte.
// Ports:
//   data_i      data word
//   parity_in_i received parity bit (check mode only)
//   mode_i      MODE_GEN or MODE_CHK
//   parity_o    ^data ^ ODD_PARITY
//   error_o     check mode: parity_in ^ computed parity; generate mode: 0
module parity_unit
  import parity_arb_pkg::*;
#(
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter bit          ODD_PARITY = 1'b0
) (
  input  logic [DATA_W-1:0] data_i,
  input  logic              parity_in_i,
  input  logic              mode_i,
  output logic              parity_o,
  output logic              error_o
);

  assign parity_o = (^data_i) ^ ODD_PARITY;
  assign error_o  = (mode_i == MODE_GEN) ? 1'b0 : (parity_in_i ^ parity_o);

endmodule

// File: rtl/parity_arb_ctrl.sv
// Purpose: round-robin sharing of one parity generate/check unit between two
// byte requesters, single result register with valid/ready, and saturating
// per-channel failed-check counters.
// Ports:
//   clk, rst                     clock, async active-high reset
//   req_valid/ready[1:0]         per-channel request handshake (ready is comb)
//   req_data/parity/mode         per-channel request payload
//   rsp_valid/ready              result handshake
//   rsp_ch/data/parity/error     registered result fields
//   err_cnt0/1, err_clr, err_flag  failed-check counters, clear and summary flag
module parity_arb_ctrl
  import parity_arb_pkg::*;
#(
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned CNT_W      = DEF_CNT_W,
  parameter bit          ODD_PARITY = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [2*DATA_W-1:0] req_data,
  input  logic [1:0]          req_parity,
  input  logic [1:0]          req_mode,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic                rsp_ch,
  output logic [DATA_W-1:0]   rsp_data,
  output logic                rsp_parity,
  output logic                rsp_error,
  output logic [CNT_W-1:0]    err_cnt0,
  output logic [CNT_W-1:0]    err_cnt1,
  input  logic                err_clr,
  output logic                err_flag
);

  state_e              state_q;
  logic                rr_q;
  logic                rsp_ch_q;
  logic [DATA_W-1:0]   rsp_data_q;
  logic                rsp_parity_q;
  logic                rsp_error_q;
  logic [CNT_W-1:0]    cnt0_q, cnt0_d;
  logic [CNT_W-1:0]    cnt1_q, cnt1_d;
  logic                flag_q;

  logic                slot_free;
  logic [1:0]          grant;
  logic                accept;
  logic                grant_ch;
  logic [DATA_W-1:0]   sel_data;
  logic                sel_parity;
  logic                sel_mode;
  logic                pu_parity;
  logic                pu_error;

  // Arbitration: a lone requester always wins, a tie goes to rr_q
  always_comb begin
    grant     = 2'b00;
    slot_free = (state_q == EMPTY) | rsp_ready;
    if (slot_free) begin
      unique case (req_valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = rr_q ? 2'b10 : 2'b01;
        default: grant = 2'b00;
      endcase
    end
  end

  assign accept    = |grant;
  assign grant_ch  = grant[1];
  assign req_ready = grant;

  // Route the granted request into the shared parity unit
  assign sel_data   = grant_ch ? req_data[2*DATA_W-1:DATA_W] : req_data[DATA_W-1:0];
  assign sel_parity = req_parity[grant_ch];
  assign sel_mode   = req_mode[grant_ch];

  parity_unit #(
    .DATA_W     (DATA_W),
    .ODD_PARITY (ODD_PARITY)
  ) u_parity_unit (
    .data_i      (sel_data),
    .parity_in_i (sel_parity),
    .mode_i      (sel_mode),
    .parity_o    (pu_parity),
    .error_o     (pu_error)
  );

  // Saturating counters; a clear beats a coincident increment
  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (err_clr) begin
      cnt0_d = '0;
      cnt1_d = '0;
    end else if (accept && pu_error) begin
      if (!grant_ch && !(&cnt0_q)) cnt0_d = cnt0_q + CNT_W'(1);
      if ( grant_ch && !(&cnt1_q)) cnt1_d = cnt1_q + CNT_W'(1);
    end
  end

  // Result-register FSM, round-robin pointer, counters and flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= EMPTY;
      rr_q         <= 1'b0;
      rsp_ch_q     <= 1'b0;
      rsp_data_q   <= '0;
      rsp_parity_q <= 1'b0;
      rsp_error_q  <= 1'b0;
      cnt0_q       <= '0;
      cnt1_q       <= '0;
      flag_q       <= 1'b0;
    end else begin
      case (state_q)
        EMPTY:   if (accept) state_q <= FULL;
        FULL:    if (rsp_ready && !accept) state_q <= EMPTY;
        default: state_q <= EMPTY;
      endcase
      if (accept) begin
        rr_q         <= ~grant_ch;
        rsp_ch_q     <= grant_ch;
        rsp_data_q   <= sel_data;
        rsp_parity_q <= pu_parity;
        rsp_error_q  <= pu_error;
      end
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
      flag_q <= (|cnt0_q) | (|cnt1_q);
    end
  end

  assign rsp_valid  = (state_q == FULL);
  assign rsp_ch     = rsp_ch_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_parity = rsp_parity_q;
  assign rsp_error  = rsp_error_q;
  assign err_cnt0   = cnt0_q;
  assign err_cnt1   = cnt1_q;
  assign err_flag   = flag_q;

endmodule

// File: tb/tb_parity_arb_ctrl.sv
// Two instances share stimulus: A (even parity, 2-bit counters) and
// B (odd parity, 8-bit counters). A queue-free behavioural model predicts
// both each cycle; a few literal expectations pin the model.
module tb_parity_arb_ctrl;

  localparam int unsigned CMAX [2] = '{3, 255};
  localparam bit          ODD  [2] = '{1'b0, 1'b1};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req_valid = '0;
  logic [15:0] req_data = '0;
  logic [1:0]  req_parity = '0;
  logic [1:0]  req_mode = '0;
  logic        rsp_ready = 1'b0;
  logic        err_clr = 1'b0;

  logic [1:0]  a_req_ready, b_req_ready;
  logic        a_rsp_valid, b_rsp_valid, a_rsp_ch, b_rsp_ch;
  logic [7:0]  a_rsp_data, b_rsp_data;
  logic        a_rsp_parity, b_rsp_parity, a_rsp_error, b_rsp_error;
  logic [1:0]  a_err_cnt0, a_err_cnt1;
  logic [7:0]  b_err_cnt0, b_err_cnt1;
  logic        a_err_flag, b_err_flag;

  int checks = 0;
  int failures = 0;

  // Model state
  logic        m_valid, m_ch, m_rr;
  logic [7:0]  m_data;
  logic        m_par [2];
  logic        m_err [2];
  int unsigned m_cnt [2][2];
  logic        m_flag [2];

  always #5 clk = ~clk;

  parity_arb_ctrl #(.DATA_W(8), .CNT_W(2), .ODD_PARITY(1'b0)) u_dut_a (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(a_req_ready),
    .req_data(req_data), .req_parity(req_parity), .req_mode(req_mode),
    .rsp_valid(a_rsp_valid), .rsp_ready(rsp_ready), .rsp_ch(a_rsp_ch),
    .rsp_data(a_rsp_data), .rsp_parity(a_rsp_parity), .rsp_error(a_rsp_error),
    .err_cnt0(a_err_cnt0), .err_cnt1(a_err_cnt1), .err_clr(err_clr),
    .err_flag(a_err_flag));

  parity_arb_ctrl #(.DATA_W(8), .CNT_W(8), .ODD_PARITY(1'b1)) u_dut_b (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(b_req_ready),
    .req_data(req_data), .req_parity(req_parity), .req_mode(req_mode),
    .rsp_valid(b_rsp_valid), .rsp_ready(rsp_ready), .rsp_ch(b_rsp_ch),
    .rsp_data(b_rsp_data), .rsp_parity(b_rsp_parity), .rsp_error(b_rsp_error),
    .err_cnt0(b_err_cnt0), .err_cnt1(b_err_cnt1), .err_clr(err_clr),
    .err_flag(b_err_flag));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_valid = 1'b0; m_ch = 1'b0; m_rr = 1'b0; m_data = '0;
    for (int k = 0; k < 2; k++) begin
      m_par[k] = 1'b0; m_err[k] = 1'b0; m_flag[k] = 1'b0;
      m_cnt[k][0] = 0; m_cnt[k][1] = 0;
    end
  endfunction

  // Which channel the spec's rules say wins this cycle (-1 = none)
  function automatic int exp_grant();
    if (m_valid && !rsp_ready) return -1;
    case (req_valid)
      2'b01:   return 0;
      2'b10:   return 1;
      2'b11:   return m_rr ? 1 : 0;
      default: return -1;
    endcase
  endfunction

  task automatic compare_registered();
    logic v, ch, p, e, f;
    logic [7:0] d;
    logic [31:0] c0, c1;
    for (int k = 0; k < 2; k++) begin
      if (k == 0) begin
        v = a_rsp_valid; ch = a_rsp_ch; d = a_rsp_data; p = a_rsp_parity;
        e = a_rsp_error; f = a_err_flag; c0 = 32'(a_err_cnt0); c1 = 32'(a_err_cnt1);
      end else begin
        v = b_rsp_valid; ch = b_rsp_ch; d = b_rsp_data; p = b_rsp_parity;
        e = b_rsp_error; f = b_err_flag; c0 = 32'(b_err_cnt0); c1 = 32'(b_err_cnt1);
      end
      chk($sformatf("rsp_valid[%0d]", k), 32'(v), 32'(m_valid));
      chk($sformatf("rsp_ch[%0d]", k), 32'(ch), 32'(m_ch));
      chk($sformatf("rsp_data[%0d]", k), 32'(d), 32'(m_data));
      chk($sformatf("rsp_parity[%0d]", k), 32'(p), 32'(m_par[k]));
      chk($sformatf("rsp_error[%0d]", k), 32'(e), 32'(m_err[k]));
      chk($sformatf("err_cnt0[%0d]", k), c0, m_cnt[k][0]);
      chk($sformatf("err_cnt1[%0d]", k), c1, m_cnt[k][1]);
      chk($sformatf("err_flag[%0d]", k), 32'(f), 32'(m_flag[k]));
    end
  endtask

  // One clock: inputs already driven at negedge; ends at the next negedge
  task automatic cycle();
    int g;
    logic [1:0] rdy;
    logic [7:0] d;
    logic pin, md, fl [2];
    #1;
    g = exp_grant();
    rdy = (g < 0) ? 2'b00 : ((g == 0) ? 2'b01 : 2'b10);
    chk("req_ready[0]", 32'(a_req_ready), 32'(rdy));
    chk("req_ready[1]", 32'(b_req_ready), 32'(rdy));
    for (int k = 0; k < 2; k++) fl[k] = (m_cnt[k][0] != 0) || (m_cnt[k][1] != 0);
    @(posedge clk);
    if (g >= 0) begin
      d   = (g == 1) ? req_data[15:8] : req_data[7:0];
      pin = req_parity[g];
      md  = req_mode[g];
      m_valid = 1'b1; m_ch = (g == 1); m_data = d; m_rr = (g == 0);
      for (int k = 0; k < 2; k++) begin
        m_par[k] = 1'(($countones(d) + int'(ODD[k])) % 2);
        m_err[k] = md ? (pin ^ m_par[k]) : 1'b0;
      end
    end else if (rsp_ready) begin
      m_valid = 1'b0;
    end
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < 2; c++) begin
        if (err_clr) m_cnt[k][c] = 0;
        else if (g == c && m_err[k] && md && m_cnt[k][c] < CMAX[k]) m_cnt[k][c]++;
      end
      m_flag[k] = fl[k];
    end
    @(negedge clk);
    compare_registered();
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    compare_registered();
    chk("reset_valid", 32'(a_rsp_valid), 32'd0);
    chk("reset_flag", 32'(a_err_flag), 32'd0);

    // ch0 generate 8'hA5: even parity 0, odd parity 1
    req_valid = 2'b01; req_data = 16'h00A5; req_mode = 2'b00; rsp_ready = 1'b0;
    cycle();
    chk("gen_valid", 32'(a_rsp_valid), 32'd1);
    chk("gen_ch", 32'(a_rsp_ch), 32'd0);
    chk("gen_par_even", 32'(a_rsp_parity), 32'd0);
    chk("gen_par_odd", 32'(b_rsp_parity), 32'd1);
    chk("gen_err", 32'(a_rsp_error), 32'd0);
    req_valid = 2'b00; rsp_ready = 1'b1;
    cycle();

    // ch1 check 8'h07 with bad then good parity
    req_valid = 2'b10; req_data = 16'h0700; req_mode = 2'b10; req_parity = 2'b00;
    cycle();
    chk("chk_err", 32'(a_rsp_error), 32'd1);
    chk("chk_cnt1", 32'(a_err_cnt1), 32'd1);
    chk("chk_err_odd", 32'(b_rsp_error), 32'd0);
    req_parity = 2'b10;
    cycle();
    chk("chk_ok_err", 32'(a_rsp_error), 32'd0);
    chk("chk_ok_cnt1", 32'(a_err_cnt1), 32'd1);
    chk("chk_flag", 32'(a_err_flag), 32'd1);

    // Hold result for 3 cycles, then release with a pending request
    rsp_ready = 1'b0; req_valid = 2'b11; req_data = 16'h5A3C; req_mode = 2'b00;
    repeat (3) begin
      cycle();
      chk("hold_ready", 32'(a_req_ready), 32'd0);
      chk("hold_data", 32'(a_rsp_data), 32'h07);
    end
    rsp_ready = 1'b1;
    cycle();
    chk("release_data", 32'(a_rsp_data), 32'h3C);
    chk("release_ch", 32'(a_rsp_ch), 32'd0);

    // Async reset while FULL, between clock edges
    req_valid = 2'b00; rsp_ready = 1'b0;
    #3 rst = 1'b1;
    #1;
    chk("areset_valid_a", 32'(a_rsp_valid), 32'd0);
    chk("areset_valid_b", 32'(b_rsp_valid), 32'd0);
    chk("areset_cnt1", 32'(a_err_cnt1), 32'd0);
    chk("areset_flag", 32'(a_err_flag), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    // Both valid, always ready: 0,1,0,1 with no bubble (rr_ptr back to 0)
    req_valid = 2'b11; req_data = 16'h2211; rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("alt_ch", 32'(a_rsp_ch), 32'(i % 2));
      chk("alt_valid", 32'(a_rsp_valid), 32'd1);
    end

    // Saturation on instance A (2-bit counters) and clear precedence
    req_valid = 2'b00; err_clr = 1'b1;
    cycle();
    err_clr = 1'b0;
    req_valid = 2'b01; req_data = 16'h0001; req_mode = 2'b01; req_parity = 2'b00;
    repeat (5) cycle();
    chk("sat_cnt0", 32'(a_err_cnt0), 32'd3);
    err_clr = 1'b1;
    cycle();
    chk("clr_cnt0", 32'(a_err_cnt0), 32'd0);
    chk("clr_flag_lag", 32'(a_err_flag), 32'd1);
    err_clr = 1'b0; req_valid = 2'b00;
    cycle();
    chk("clr_flag_fall", 32'(a_err_flag), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      req_valid  = 2'($urandom_range(0, 3));
      req_data   = 16'($urandom);
      req_parity = 2'($urandom_range(0, 3));
      req_mode   = 2'($urandom_range(0, 3));
      rsp_ready  = ($urandom_range(0, 9) < 7);
      err_clr    = ($urandom_range(0, 63) == 0);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
